// File: rtl/ccip_avmm_csr_responder.sv
// ccip_avmm_csr_responder
// Avalon-MM slave implementing the AFU's 64-bit CSR space (DFH, AFU ID, control,
// status, cycle/access counters, scratch). Reads return at a fixed latency so the
// upstream bridge can pair responses with requests in order.
module ccip_avmm_csr_responder #(
    parameter logic [63:0] DFH_VALUE                 = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_ID_L                  = 64'h0,
    parameter logic [63:0] AFU_ID_H                  = 64'h0,
    parameter int          NUM_SCRATCH               = 4,
    parameter int          READ_LATENCY              = 2,
    parameter int          WRITE_STALL               = 1,
    parameter int          CCIP_AVMM_MMIO_ADDR_WIDTH = 18,
    parameter int          CCIP_AVMM_MMIO_DATA_WIDTH = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,
    output logic                                   avmm_waitrequest,
    output logic [CCIP_AVMM_MMIO_DATA_WIDTH-1:0]   avmm_readdata,
    output logic                                   avmm_readdatavalid,
    input  logic [CCIP_AVMM_MMIO_DATA_WIDTH-1:0]   avmm_writedata,
    input  logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0]   avmm_address,
    input  logic                                   avmm_write,
    input  logic                                   avmm_read,
    input  logic [CCIP_AVMM_MMIO_DATA_WIDTH/8-1:0] avmm_byteenable,
    output logic [CCIP_AVMM_MMIO_DATA_WIDTH-1:0]   csr_ctrl,
    input  logic [CCIP_AVMM_MMIO_DATA_WIDTH-1:0]   csr_status
);

    localparam int DW = CCIP_AVMM_MMIO_DATA_WIDTH;
    localparam int AW = CCIP_AVMM_MMIO_ADDR_WIDTH;
    localparam int QW = AW - 3;
    localparam int BW = DW / 8;

    // Qword indices of the register map
    localparam logic [QW-1:0] IDX_DFH    = QW'(0);
    localparam logic [QW-1:0] IDX_AFU_L  = QW'(1);
    localparam logic [QW-1:0] IDX_AFU_H  = QW'(2);
    localparam logic [QW-1:0] IDX_CTRL   = QW'(4);
    localparam logic [QW-1:0] IDX_STATUS = QW'(5);
    localparam logic [QW-1:0] IDX_CYCLE  = QW'(6);
    localparam logic [QW-1:0] IDX_COUNTS = QW'(7);
    localparam int            IDX_SCR0   = 8;

    logic              stall_q;
    logic              rd_acc;
    logic              wr_acc;
    logic              counts_clear;
    logic [QW-1:0]     qidx;
    logic [DW-1:0]     ctrl_q;
    logic [DW-1:0]     status_q;
    logic [63:0]       cycle_q;
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;
    logic [DW-1:0]     scratch_q [NUM_SCRATCH];
    logic [DW-1:0]     rd_mux;
    logic              pipe_valid [READ_LATENCY];
    logic [DW-1:0]     pipe_data  [READ_LATENCY];
    logic              rdv_q;
    logic [DW-1:0]     rdata_q;
    logic              unused_addr_bits;

    // Byte-lane merge: only enabled lanes take the new data
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [BW-1:0] be);
        logic [DW-1:0] res;
        res = old_val;
        for (int k = 0; k < BW; k++) begin
            if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

    assign qidx             = avmm_address[AW-1:3];
    assign unused_addr_bits = ^avmm_address[2:0];
    assign avmm_waitrequest = stall_q | reset;
    assign rd_acc           = avmm_read  & ~avmm_waitrequest;
    assign wr_acc           = avmm_write & ~avmm_waitrequest;
    assign counts_clear     = wr_acc && (qidx == IDX_COUNTS);

    assign csr_ctrl           = ctrl_q;
    assign avmm_readdata      = rdata_q;
    assign avmm_readdatavalid = rdv_q & ~reset;

    // Stall for one cycle after reset release and (optionally) after each accepted write
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) stall_q <= 1'b1;
        else       stall_q <= (WRITE_STALL != 0) && wr_acc;
    end

    // Status sampling and free-running cycle counter
    always_ff @(posedge clk) begin
        status_q <= csr_status;
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_q + 64'd1;
    end

    // Writable registers: CTRL and scratch, byte-lane granular
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
        end else if (wr_acc) begin
            if (qidx == IDX_CTRL) ctrl_q <= merge_bytes(ctrl_q, avmm_writedata, avmm_byteenable);
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (qidx == QW'(IDX_SCR0 + i))
                    scratch_q[i] <= merge_bytes(scratch_q[i], avmm_writedata, avmm_byteenable);
            end
        end
    end

    // Saturating access counters; a COUNTS write clears both and beats any increment
    always_ff @(posedge clk) begin
        if (reset || counts_clear) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_acc && (rd_count != 32'hFFFF_FFFF)) rd_count <= rd_count + 32'd1;
            if (wr_acc && (wr_count != 32'hFFFF_FFFF)) wr_count <= wr_count + 32'd1;
        end
    end

    // Read decode on current register values, i.e. the pre-write snapshot
    always_comb begin
        // NOTE: defaulting every output first keeps this block free of latches.
        rd_mux = '0;
        case (qidx)
            IDX_DFH:    rd_mux = DFH_VALUE;
            IDX_AFU_L:  rd_mux = AFU_ID_L;
            IDX_AFU_H:  rd_mux = AFU_ID_H;
            IDX_CTRL:   rd_mux = ctrl_q;
            IDX_STATUS: rd_mux = status_q;
            IDX_CYCLE:  rd_mux = cycle_q;
            IDX_COUNTS: rd_mux = {rd_count, wr_count};
            default:    rd_mux = '0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (qidx == QW'(IDX_SCR0 + i)) rd_mux = scratch_q[i];
        end
    end

    // Read pipeline valid bits and output register; reset drops in-flight reads
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe_valid[i] <= 1'b0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            pipe_valid[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
            rdv_q <= pipe_valid[READ_LATENCY-1];
            if (pipe_valid[READ_LATENCY-1]) rdata_q <= pipe_data[READ_LATENCY-1];
        end
    end

    // Read pipeline data lanes
    always_ff @(posedge clk) begin
        // NOTE: data stages are not reset; their valid bits alone decide whether they matter.
        pipe_data[0] <= rd_mux;
        for (int i = 1; i < READ_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
    end

endmodule
